// File: rtl/lpc_io_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpc_io_host : LPC host initiator for single-byte I/O read/write cycles.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lpc_io_host #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int WAIT_MAX     = 1024
) (
  input  logic        lclk,
  input  logic        lreset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        lframe_n,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic [3:0]  lad_in
);

  localparam int c_WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int c_NOSYNC_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0]   c_WAIT_MAX   = c_WAIT_W'(WAIT_MAX);
  localparam logic [c_NOSYNC_W-1:0] c_SYNC_LIMIT = c_NOSYNC_W'(SYNC_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_CYCTYP    = 4'd2,
    S_ADDR      = 4'd3,
    S_WDATA     = 4'd4,
    S_TAR_H1    = 4'd5,
    S_TAR_H2    = 4'd6,
    S_SYNC      = 4'd7,
    S_RDATA     = 4'd8,
    S_TAR_P1    = 4'd9,
    S_TAR_P2    = 4'd10,
    S_ABORT     = 4'd11,
    S_ABORT_END = 4'd12,
    S_DONE      = 4'd13
  } state_t;

  state_t                  r_state, w_state_nx;
  logic [1:0]              r_nib, w_nib_nx;
  logic [c_WAIT_W-1:0]     r_wait_cnt, w_wait_nx, w_wait_inc;
  logic [c_NOSYNC_W-1:0]   r_nosync_cnt, w_nosync_nx, w_nosync_inc;
  logic                    r_err_flag, w_err_nx;
  logic                    r_write, w_write_nx;
  logic [15:0]             r_addr, w_addr_nx;
  logic [7:0]              r_wdata, w_wdata_nx;
  logic [7:0]              r_rbuf, w_rbuf_nx;
  logic                    w_rsp_valid_nx;
  logic [7:0]              w_rsp_rdata_nx;
  logic [1:0]              w_rsp_err_nx;
  logic                    w_lframe_n_nx, w_lad_oe_nx, w_req_ready_nx;
  logic [3:0]              w_lad_out_nx;

  assign w_wait_inc   = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + c_WAIT_W'(1);
  assign w_nosync_inc = (r_nosync_cnt == c_SYNC_LIMIT) ? r_nosync_cnt
                                                        : r_nosync_cnt + c_NOSYNC_W'(1);

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_state      <= S_IDLE;
      r_nib        <= 2'd0;
      r_wait_cnt   <= '0;
      r_nosync_cnt <= '0;
      r_err_flag   <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 16'h0000;
      r_wdata      <= 8'h00;
      r_rbuf       <= 8'h00;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 2'b00;
      lframe_n     <= 1'b1;
      lad_out      <= 4'hF;
      lad_oe       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_nib        <= w_nib_nx;
      r_wait_cnt   <= w_wait_nx;
      r_nosync_cnt <= w_nosync_nx;
      r_err_flag   <= w_err_nx;
      r_write      <= w_write_nx;
      r_addr       <= w_addr_nx;
      r_wdata      <= w_wdata_nx;
      r_rbuf       <= w_rbuf_nx;
      req_ready    <= w_req_ready_nx;
      rsp_valid    <= w_rsp_valid_nx;
      rsp_rdata    <= w_rsp_rdata_nx;
      rsp_err      <= w_rsp_err_nx;
      lframe_n     <= w_lframe_n_nx;
      lad_out      <= w_lad_out_nx;
      lad_oe       <= w_lad_oe_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_nib_nx       = r_nib;
    w_wait_nx      = r_wait_cnt;
    w_nosync_nx    = r_nosync_cnt;
    w_err_nx       = r_err_flag;
    w_write_nx     = r_write;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_rbuf_nx      = r_rbuf;
    w_rsp_valid_nx = 1'b0;
    w_rsp_rdata_nx = rsp_rdata;
    w_rsp_err_nx   = rsp_err;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_write_nx  = req_write;
          w_addr_nx   = req_addr;
          w_wdata_nx  = req_wdata;
          w_wait_nx   = '0;
          w_nosync_nx = '0;
          w_err_nx    = 1'b0;
          w_state_nx  = S_START;
        end
      end
      S_START:  w_state_nx = S_CYCTYP;
      S_CYCTYP: begin
        w_state_nx = S_ADDR;
        w_nib_nx   = 2'd0;
      end
      S_ADDR: begin
        if (r_nib == 2'd3) begin
          w_state_nx = r_write ? S_WDATA : S_TAR_H1;
          w_nib_nx   = 2'd0;
        end else begin
          w_nib_nx = r_nib + 2'd1;
        end
      end
      S_WDATA: begin
        if (r_nib == 2'd1) w_state_nx = S_TAR_H1;
        else               w_nib_nx   = r_nib + 2'd1;
      end
      S_TAR_H1: w_state_nx = S_TAR_H2;
      S_TAR_H2: w_state_nx = S_SYNC;
      S_SYNC: begin
        // 1010 marks an error but the data phase still runs to completion
        if (lad_in == 4'b0000 || lad_in == 4'b1010) begin
          if (lad_in == 4'b1010) w_err_nx = 1'b1;
          w_state_nx = r_write ? S_TAR_P1 : S_RDATA;
          w_nib_nx   = 2'd0;
        end else if (lad_in == 4'b0101 || lad_in == 4'b0110) begin
          w_wait_nx   = w_wait_inc;
          w_nosync_nx = '0;
          if (w_wait_inc == c_WAIT_MAX) begin
            w_state_nx = S_ABORT;
            w_nib_nx   = 2'd0;
          end
        end else begin
          w_nosync_nx = w_nosync_inc;
          if (w_nosync_inc == c_SYNC_LIMIT) begin
            w_state_nx = S_ABORT;
            w_nib_nx   = 2'd0;
          end
        end
      end
      S_RDATA: begin
        if (r_nib == 2'd0) begin
          w_rbuf_nx[3:0] = lad_in;
          w_nib_nx       = 2'd1;
        end else begin
          w_rbuf_nx[7:4] = lad_in;
          w_state_nx     = S_TAR_P1;
        end
      end
      S_TAR_P1: w_state_nx = S_TAR_P2;
      S_TAR_P2: begin
        w_state_nx     = S_DONE;
        w_rsp_valid_nx = 1'b1;
        w_rsp_err_nx   = r_err_flag ? 2'b10 : 2'b00;
        if (!r_write) w_rsp_rdata_nx = r_rbuf;
      end
      S_ABORT: begin
        if (r_nib == 2'd3) w_state_nx = S_ABORT_END;
        else               w_nib_nx   = r_nib + 2'd1;
      end
      S_ABORT_END: begin
        w_state_nx     = S_DONE;
        w_rsp_valid_nx = 1'b1;
        w_rsp_err_nx   = 2'b01;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state so every output is a flop.
  always_comb begin
    w_lframe_n_nx  = 1'b1;
    w_lad_oe_nx    = 1'b0;
    w_lad_out_nx   = 4'hF;
    w_req_ready_nx = (w_state_nx == S_IDLE);
    unique case (w_state_nx)
      S_START: begin
        w_lframe_n_nx = 1'b0;
        w_lad_oe_nx   = 1'b1;
        w_lad_out_nx  = 4'h0;
      end
      S_CYCTYP: begin
        w_lad_oe_nx  = 1'b1;
        w_lad_out_nx = {2'b00, w_write_nx, 1'b0};
      end
      S_ADDR: begin
        w_lad_oe_nx  = 1'b1;
        w_lad_out_nx = w_addr_nx[{~w_nib_nx, 2'b00} +: 4];
      end
      S_WDATA: begin
        w_lad_oe_nx  = 1'b1;
        w_lad_out_nx = w_wdata_nx[{w_nib_nx[0], 2'b00} +: 4];
      end
      S_TAR_H1: w_lad_oe_nx = 1'b1;
      S_ABORT: begin
        w_lframe_n_nx = 1'b0;
        w_lad_oe_nx   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lpc_io_host.sv
`default_nettype none
// Bench for lpc_io_host: scripted LPC peripheral plus a phase-list model of the bus.
module tb_lpc_io_host;

  logic        lclk = 1'b0;
  logic        lreset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        lframe_n;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in = 4'hF;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       lf;
    logic       oe;
    logic [3:0] lad;
    logic       rv;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] g_pre[$];
  logic [3:0] script[0:1199];
  logic [7:0] model_rdata = 8'h00;

  lpc_io_host dut (
    .lclk      (lclk),
    .lreset_n  (lreset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .lframe_n  (lframe_n),
    .lad_out   (lad_out),
    .lad_oe    (lad_oe),
    .lad_in    (lad_in)
  );

  always #5 lclk = ~lclk;

  function automatic exp_t mk(input logic lf, input logic oe, input logic [3:0] lad, input logic rv);
    mk = {lf, oe, lad, rv};
  endfunction

  // Builds the expected bus phases from the protocol, scripts the peripheral's
  // LAD responses, then steps cycle N+1 .. N+L+1 comparing every cycle.
  task automatic run_txn(input string name, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input bit abort, input logic [3:0] fin,
                         input logic [7:0] rd, input bit hold,
                         input logic [15:0] naddr, input logic [7:0] nwd);
    int s0;
    int n;
    logic [1:0] exp_err;
    exp_t e;
    expq.delete();
    for (int i = 0; i < 1200; i++) script[i] = 4'hF;
    expq.push_back(mk(1'b0, 1'b1, 4'h0, 1'b0));
    expq.push_back(mk(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 1'b0));
    for (int i = 0; i < 4; i++) expq.push_back(mk(1'b1, 1'b1, addr[15-4*i -: 4], 1'b0));
    if (wr) begin
      expq.push_back(mk(1'b1, 1'b1, wd[3:0], 1'b0));
      expq.push_back(mk(1'b1, 1'b1, wd[7:4], 1'b0));
    end
    expq.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0));
    expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
    s0 = expq.size() + 1;
    foreach (g_pre[i]) begin
      script[s0 + i] = g_pre[i];
      expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
    end
    if (abort) begin
      for (int i = 0; i < 4; i++) expq.push_back(mk(1'b0, 1'b1, 4'hF, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
      exp_err = 2'b01;
    end else begin
      script[s0 + g_pre.size()] = fin;
      expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
      if (!wr) begin
        script[s0 + g_pre.size() + 1] = rd[3:0];
        script[s0 + g_pre.size() + 2] = rd[7:4];
        expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
        expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
        model_rdata = rd;
      end
      expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b0));
      exp_err = (fin == 4'hA) ? 2'b10 : 2'b00;
    end
    expq.push_back(mk(1'b1, 1'b0, 4'hF, 1'b1));
    n = expq.size();

    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge lclk); #1;
      if (k == 1) begin
        if (hold) begin
          req_addr  = naddr;
          req_wdata = nwd;
        end else begin
          req_valid = 1'b0;
          req_addr  = 16'($urandom);
          req_wdata = 8'($urandom);
        end
      end
      if (k <= n) begin
        e = expq[k-1];
        checks++;
        if (lframe_n !== e.lf || lad_oe !== e.oe || (e.oe && lad_out !== e.lad) ||
            rsp_valid !== e.rv || req_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s bus k=%0d got lf=%b oe=%b lad=%h rv=%b rdy=%b want lf=%b oe=%b lad=%h rv=%b rdy=0",
                   name, k, lframe_n, lad_oe, lad_out, rsp_valid, req_ready, e.lf, e.oe, e.lad, e.rv);
        end
        if (e.rv) begin
          checks++;
          if (rsp_err !== exp_err || rsp_rdata !== model_rdata) begin
            failures++;
            $display("FAIL %s rsp got err=%b rdata=%h want err=%b rdata=%h",
                     name, rsp_err, rsp_rdata, exp_err, model_rdata);
          end
        end
      end else begin
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || lframe_n !== 1'b1 || lad_oe !== 1'b0) begin
          failures++;
          $display("FAIL %s idle got rdy=%b rv=%b lf=%b oe=%b want rdy=1 rv=0 lf=1 oe=0",
                   name, req_ready, rsp_valid, lframe_n, lad_oe);
        end
      end
      lad_in = script[k];
    end
    lad_in = 4'hF;
  endtask

  task automatic test_reset();
    lreset_n = 1'b0;
    repeat (3) @(posedge lclk);
    #1;
    checks++;
    if (lframe_n !== 1'b1 || lad_out !== 4'hF || lad_oe !== 1'b0 || req_ready !== 1'b1 ||
        rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 2'b00) begin
      failures++;
      $display("FAIL reset got lf=%b lad=%h oe=%b rdy=%b rv=%b rd=%h err=%b want 1 f 0 1 0 00 00",
               lframe_n, lad_out, lad_oe, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge lclk);
    lreset_n = 1'b1;
    @(posedge lclk); #1;
  endtask

  task automatic test_write_basic();
    g_pre.delete();
    run_txn("write_0774", 1'b1, 16'h0774, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_read_waits();
    g_pre.delete();
    g_pre.push_back(4'h5);
    g_pre.push_back(4'h5);
    run_txn("read_waits", 1'b0, 16'h0705, 8'h00, 1'b0, 4'h0, 8'h09, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_no_peripheral();
    g_pre.delete();
    for (int i = 0; i < 8; i++) g_pre.push_back(4'hF);
    run_txn("no_periph", 1'b0, 16'h0704, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_sync_error();
    g_pre.delete();
    run_txn("sync_err_rd", 1'b0, 16'h0770, 8'h00, 1'b0, 4'hA, 8'hC3, 1'b0, 16'h0, 8'h0);
    run_txn("sync_err_wr", 1'b1, 16'h0771, 8'h3C, 1'b0, 4'hA, 8'h00, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_nosync_clear();
    g_pre.delete();
    for (int i = 0; i < 7; i++) g_pre.push_back(4'hF);
    g_pre.push_back(4'h6);
    for (int i = 0; i < 7; i++) g_pre.push_back(4'h3);
    run_txn("nosync_clear", 1'b0, 16'h0777, 8'h00, 1'b0, 4'h0, 8'h5E, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_wait_max();
    g_pre.delete();
    for (int i = 0; i < 1024; i++) g_pre.push_back((i % 2 == 0) ? 4'h5 : 4'h6);
    run_txn("wait_max", 1'b1, 16'h0706, 8'h77, 1'b1, 4'h0, 8'h00, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_back_to_back();
    g_pre.delete();
    run_txn("b2b_first", 1'b1, 16'h0774, 8'h11, 1'b0, 4'h0, 8'h00, 1'b1, 16'h0775, 8'h22);
    run_txn("b2b_second", 1'b1, 16'h0775, 8'h22, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_reset_mid_cycle();
    bit seen;
    req_write = 1'b0;
    req_addr  = 16'h0704;
    req_valid = 1'b1;
    @(posedge lclk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge lclk);
    #3;
    lreset_n = 1'b0;
    #1;
    checks++;
    if (lframe_n !== 1'b1 || lad_oe !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got lf=%b oe=%b rdy=%b rv=%b want lf=1 oe=0 rdy=1 rv=0",
               lframe_n, lad_oe, req_ready, rsp_valid);
    end
    model_rdata = 8'h00;
    repeat (2) @(posedge lclk);
    @(negedge lclk);
    lreset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge lclk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_rsp got rsp_valid pulse=1 want 0");
    end
    g_pre.delete();
    run_txn("after_reset", 1'b0, 16'h0772, 8'h00, 1'b0, 4'h0, 8'hB4, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_random();
    logic [3:0] pool[4];
    pool[0] = 4'h5; pool[1] = 4'h6; pool[2] = 4'hF; pool[3] = 4'h3;
    for (int t = 0; t < 24; t++) begin
      int npre;
      bit wr;
      logic [15:0] a;
      g_pre.delete();
      npre = $urandom_range(0, 3);
      for (int i = 0; i < npre; i++) g_pre.push_back(pool[$urandom_range(0, 3)]);
      wr = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0770 + 16'($urandom_range(0, 7));
      run_txn("random", wr, a, 8'($urandom), 1'b0,
              ($urandom_range(0, 3) == 0) ? 4'hA : 4'h0, 8'($urandom), 1'b0, 16'h0, 8'h0);
      repeat ($urandom_range(0, 2)) @(posedge lclk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_waits();
    test_no_peripheral();
    test_sync_error();
    test_nosync_clear();
    test_back_to_back();
    test_wait_max();
    test_random();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
